seq_decoder: RTL and testbench

- Parametrised successor to the team's combinational 3-to-8 decoder.
- Converts a binary select into a registered one-hot output vector, accepted under a valid/ready handshake.
- Adds an autonomous scan mode that walks a single active bit across all outputs, up or down, with a programmable dwell time.
- Used as a registered row/channel-select driver and for LED/mux scanning.

---
 rtl/seq_decoder.sv | 136 +++++++++++++
 tb/tb_seq_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// Registered binary-to-one-hot decoder with valid/ready direct requests
// and an autonomous up/down scan mode with programmable dwell.
module seq_decoder #(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               scan_start,
  input  logic               scan_dir,
  input  logic               scan_abort,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid,
  output logic               err,
  output logic               scan_busy,
  output logic               scan_done
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [SEL_W:0]   OUT_W_C = (SEL_W+1)'(OUT_W);
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(OUT_W-1);

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwl_q, dwl_d;
  logic                 dir_q, dir_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic                 ov_q, ov_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [SEL_W-1:0]     nxt_idx;
  logic                 at_last;

  // Range-checked decode; indices at or above OUT_W yield all-zero.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = '0;
    for (int k = 0; k < OUT_W; k++)
      if ({1'b0, i} == (SEL_W+1)'(k)) onehot[k] = 1'b1;
  endfunction

  assign in_ready  = (state_q == IDLE) && !scan_start;
  assign out       = out_q;
  assign out_valid = ov_q;
  assign err       = err_q;
  assign scan_busy = (state_q == SCAN);
  assign scan_done = done_q;

  assign nxt_idx = dir_q ? idx_q - SEL_W'(1) : idx_q + SEL_W'(1);
  assign at_last = dir_q ? (idx_q == '0) : (idx_q == LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwl_d   = dwl_q;
    dir_d   = dir_q;
    out_d   = out_q;
    ov_d    = ov_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          dir_d   = scan_dir;
          dwl_d   = dwell;
          cnt_d   = '0;
          idx_d   = scan_dir ? LAST : '0;
          out_d   = onehot(scan_dir ? LAST : '0);
          ov_d    = 1'b1;
          err_d   = 1'b0;
        end else if (in_valid) begin
          ov_d  = 1'b1;
          err_d = ({1'b0, in_sel} >= OUT_W_C);
          out_d = onehot(in_sel);
        end
      end
      SCAN: begin
        if (scan_abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          out_d   = '0;
          ov_d    = 1'b0;
        end else if (cnt_q == dwl_q) begin
          cnt_d = '0;
          if (at_last) begin
            state_d = IDLE;
            idx_d   = '0;
            out_d   = '0;
            ov_d    = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = nxt_idx;
            out_d = onehot(nxt_idx);
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwl_q   <= '0;
      dir_q   <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwl_q   <= dwl_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Bench for seq_decoder: directed steps plus randomized transfers and
// scans checked against a sequence-level reference model.
module tb_seq_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, scan_start, scan_dir, scan_abort;
  logic [2:0] in_sel;
  logic [7:0] dwell;
  logic       in_ready, out_valid, err, scan_busy, scan_done;
  logic [7:0] out;

  logic       b_in_valid;
  logic [2:0] b_in_sel;
  logic       b_in_ready, b_out_valid, b_err, b_scan_busy, b_scan_done;
  logic [5:0] b_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_out;
  logic       exp_ov;
  logic       exp_err;

  always #5 clk = ~clk;

  seq_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .scan_start(scan_start), .scan_dir(scan_dir),
    .scan_abort(scan_abort), .dwell(dwell),
    .out(out), .out_valid(out_valid), .err(err),
    .scan_busy(scan_busy), .scan_done(scan_done)
  );

  seq_decoder #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sel(b_in_sel),
    .scan_start(1'b0), .scan_dir(1'b0),
    .scan_abort(1'b0), .dwell(8'd0),
    .out(b_out), .out_valid(b_out_valid), .err(b_err),
    .scan_busy(b_scan_busy), .scan_done(b_scan_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [7:0] o,
                          input logic ov, input logic e,
                          input logic busy, input logic done);
    chk({tag, ".out"}, 32'(out), 32'(o));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".busy"}, 32'(scan_busy), 32'(busy));
    chk({tag, ".done"}, 32'(scan_done), 32'(done));
  endtask

  // Direct request: model says one-hot of sel (OUT_W=8 covers all codes).
  task automatic xfer(input logic v, input logic [2:0] s);
    in_valid = v;
    in_sel   = s;
    #1;
    chk("xfer.in_ready", 32'(in_ready), 32'd1);
    if (v) begin
      exp_out = 8'd1 << s;
      exp_ov  = 1'b1;
      exp_err = 1'b0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_main("xfer", exp_out, exp_ov, exp_err, 1'b0, 1'b0);
  endtask

  // Scan model: step k of OUT_W*(d+1) shows index k/(d+1), mirrored if down.
  // abort_at/ign_at < 0 disables the abort or the spurious restart pulse.
  task automatic run_scan(input logic dir, input int d, input int abort_at,
                          input int ign_at, input logic with_req);
    int total;
    int idx;
    logic [7:0] e;
    total = 8 * (d + 1);
    scan_start = 1'b1;
    scan_dir   = dir;
    dwell      = 8'(d);
    in_valid   = with_req;
    in_sel     = 3'($urandom_range(0, 7));
    #1;
    chk("scan.start_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    scan_start = 1'b0;
    in_valid   = 1'b0;
    scan_dir   = ~dir;
    dwell      = 8'($urandom_range(0, 255));
    for (int k = 0; k < total; k++) begin
      idx = k / (d + 1);
      e = 8'd1 << (dir ? 7 - idx : idx);
      chk_main("scan", e, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("scan.in_ready", 32'(in_ready), 32'd0);
      scan_start = (k == ign_at);
      if (k == abort_at) begin
        scan_abort = 1'b1;
        step();
        scan_abort = 1'b0;
        scan_start = 1'b0;
        chk_main("abort", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("abort.no_done", 32'(scan_done), 32'd0);
        chk("abort.in_ready", 32'(in_ready), 32'd1);
        exp_out = 8'd0;
        exp_ov  = 1'b0;
        exp_err = 1'b0;
        return;
      end
      step();
    end
    scan_start = 1'b0;
    chk_main("scan.end", 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("scan.end_ready", 32'(in_ready), 32'd1);
    step();
    chk("scan.done_pulse", 32'(scan_done), 32'd0);
    exp_out = 8'd0;
    exp_ov  = 1'b0;
    exp_err = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = '0;
    scan_start = 1'b0;
    scan_dir   = 1'b0;
    scan_abort = 1'b0;
    dwell      = '0;
    b_in_valid = 1'b0;
    b_in_sel   = '0;
    exp_out    = '0;
    exp_ov     = 1'b0;
    exp_err    = 1'b0;
    #3;
    chk_main("reset", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) xfer(1'b1, 3'(i));
    step();
    chk_main("hold", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);

    b_in_valid = 1'b1;
    b_in_sel   = 3'b110;
    step();
    b_in_sel   = 3'b101;
    chk("b.out_oor", 32'(b_out), 32'd0);
    chk("b.err_oor", 32'(b_err), 32'd1);
    chk("b.ov_oor", 32'(b_out_valid), 32'd1);
    step();
    b_in_valid = 1'b0;
    chk("b.out_top", 32'(b_out), 32'h20);
    chk("b.err_top", 32'(b_err), 32'd0);
    b_in_valid = 1'b1;
    b_in_sel   = 3'b111;
    step();
    b_in_valid = 1'b0;
    chk("b.out_7", 32'(b_out), 32'd0);
    chk("b.err_7", 32'(b_err), 32'd1);

    run_scan(1'b0, 2, -1, -1, 1'b0);
    run_scan(1'b1, 0, -1, 3, 1'b1);
    run_scan(1'b0, 5, 20, -1, 1'b0);
    run_scan(1'b1, 1, 15, -1, 1'b0);

    // Asynchronous reset while index 4 (0x10) is showing.
    scan_start = 1'b1;
    scan_dir   = 1'b0;
    dwell      = 8'd3;
    step();
    scan_start = 1'b0;
    for (int k = 0; k < 16; k++) step();
    chk("rst.pre_out", 32'(out), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_main("rst.async", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_out = 8'd0;
    exp_ov  = 1'b0;
    exp_err = 1'b0;
    step();
    chk_main("rst.idle", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 3'd2);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        int d;
        int ab;
        d  = $urandom_range(0, 3);
        ab = ($urandom_range(0, 1) == 1) ?
             $urandom_range(0, 8 * (d + 1) - 1) : -1;
        run_scan(1'($urandom_range(0, 1)), d, ab,
                 $urandom_range(0, 8), 1'($urandom_range(0, 1)));
      end else begin
        xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
